// File: rtl/eggtimer_pkg.sv
// Shared types and constants for the egg timer sequencer: FSM state encoding,
// per-digit wrap limits and digit indices used by sel_digit.
package eggtimer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3
  } state_t;

  localparam logic [3:0] SEC_MAX  = 4'd9;
  localparam logic [3:0] TSEC_MAX = 4'd5;
  localparam logic [3:0] MIN_MAX  = 4'd9;
  localparam logic [3:0] TMIN_MAX = 4'd9;

  localparam logic [1:0] DIG_SEC  = 2'd0;
  localparam logic [1:0] DIG_TSEC = 2'd1;
  localparam logic [1:0] DIG_MIN  = 2'd2;
  localparam logic [1:0] DIG_TMIN = 2'd3;

endpackage

// File: rtl/eggtimer_ctrl_if.sv
// Sequencer <-> countdown block bus: live BCD count in, run gate, load strobe
// and programmed cook time out. No handshake; all signals are level-valid every cycle.
interface eggtimer_ctrl_if;
  logic [3:0] seconds;
  logic [3:0] tens_seconds;
  logic [3:0] minutes;
  logic [3:0] tens_minutes;
  logic       main_enable;
  logic       ctr_reset;
  logic [3:0] seconds_prog;
  logic [3:0] tens_seconds_prog;
  logic [3:0] minutes_prog;
  logic [3:0] tens_minutes_prog;

  modport master (
    input  seconds, tens_seconds, minutes, tens_minutes,
    output main_enable, ctr_reset,
    output seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog
  );

  modport slave (
    output seconds, tens_seconds, minutes, tens_minutes,
    input  main_enable, ctr_reset,
    input  seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog
  );
endinterface

// File: rtl/eggtimer_ctrl_prog_digit.sv
// One programmable BCD digit: +1 per inc strobe, wraps MAX -> 0; value updates
// one cycle after inc, no backpressure.
module prog_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [3:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= 4'd0;
    end else if (inc) begin
      value <= (value == MAX) ? 4'd0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/eggtimer_ctrl.sv
// Egg timer sequencer: edits cook time in IDLE, gates/loads the countdown, raises alarm in DONE.
// One-cycle latency from button pulse to state change; no backpressure. EGGTIMER_ALARM_TIMEOUT_EN adds alarm auto-clear.
module eggtimer_ctrl
  import eggtimer_pkg::*;
`ifdef EGGTIMER_ALARM_TIMEOUT_EN
  #(parameter int ALARM_SECS = 30)
`endif
(
  input  logic           clk,
  input  logic           reset,
  input  logic           tick_1hz,
  input  logic           btn_start,
  input  logic           btn_stop,
  input  logic           btn_sel,
  input  logic           btn_inc,
  eggtimer_ctrl_if.master ctr,
  output logic [1:0]     sel_digit,
  output logic           alarm,
  output logic [2:0]     state
);

  state_t     state_q, state_d;
  logic [1:0] sel_q;
  logic [3:0] sec_q, tsec_q, min_q, tmin_q;
  logic [3:0] inc_vec;
  logic       edit_en, count_zero, prog_zero, any_btn;

  assign edit_en    = (state_q == IDLE);
  assign any_btn    = btn_start | btn_stop | btn_sel | btn_inc;
  assign count_zero = (ctr.seconds == 4'd0) && (ctr.tens_seconds == 4'd0) &&
                      (ctr.minutes == 4'd0) && (ctr.tens_minutes == 4'd0);
  assign prog_zero  = (sec_q == 4'd0) && (tsec_q == 4'd0) &&
                      (min_q == 4'd0) && (tmin_q == 4'd0);

  // Increment targets the selection held this cycle, before any btn_sel advance.
  always_comb begin
    inc_vec = 4'b0000;
    if (edit_en && btn_inc) begin
      inc_vec[sel_q] = 1'b1;
    end
  end

  prog_digit #(.MAX(SEC_MAX))  u_sec  (.clk(clk), .reset(reset), .inc(inc_vec[DIG_SEC]),  .value(sec_q));
  prog_digit #(.MAX(TSEC_MAX)) u_tsec (.clk(clk), .reset(reset), .inc(inc_vec[DIG_TSEC]), .value(tsec_q));
  prog_digit #(.MAX(MIN_MAX))  u_min  (.clk(clk), .reset(reset), .inc(inc_vec[DIG_MIN]),  .value(min_q));
  prog_digit #(.MAX(TMIN_MAX)) u_tmin (.clk(clk), .reset(reset), .inc(inc_vec[DIG_TMIN]), .value(tmin_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= DIG_SEC;
    end else if (edit_en && btn_sel) begin
      sel_q <= sel_q + 2'd1;
    end
  end

`ifdef EGGTIMER_ALARM_TIMEOUT_EN
  localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECS - 1);
  logic [7:0] alarm_cnt;
  logic       alarm_expire;

  assign alarm_expire = tick_1hz && (alarm_cnt == ALARM_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_cnt <= 8'd0;
    end else if (state_q != DONE) begin
      alarm_cnt <= 8'd0;
    end else if (tick_1hz) begin
      alarm_cnt <= alarm_cnt + 8'd1;
    end
  end
`else
  logic unused_tick;
  logic alarm_expire;
  assign unused_tick  = tick_1hz;
  assign alarm_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // btn_stop outranks btn_start everywhere; in RUN a reached zero outranks pause.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!btn_stop && btn_start && !prog_zero) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (btn_stop) begin
          state_d = IDLE;
        end else if (count_zero) begin
          state_d = DONE;
        end else if (btn_start) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (btn_stop) begin
          state_d = IDLE;
        end else if (btn_start) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (any_btn || alarm_expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ctr.ctr_reset         = (state_q == IDLE);
  assign ctr.main_enable       = (state_q == RUN) && !count_zero;
  assign ctr.seconds_prog      = sec_q;
  assign ctr.tens_seconds_prog = tsec_q;
  assign ctr.minutes_prog      = min_q;
  assign ctr.tens_minutes_prog = tmin_q;
  assign alarm                 = (state_q == DONE);
  assign sel_digit             = sel_q;
  assign state                 = state_q;

endmodule

// File: tb/tb_eggtimer_ctrl.sv
// Scoreboard bench for eggtimer_ctrl: a total-seconds reference model predicts every
// cycle's outputs and a countdown stand-in drives the count inputs.
module tb_eggtimer_ctrl;

`ifdef EGGTIMER_ALARM_TIMEOUT_EN
  localparam int ALARM_SECS = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_sel = 1'b0;
  logic       btn_inc = 1'b0;
  logic [1:0] sel_digit;
  logic       alarm;
  logic [2:0] state;

  eggtimer_ctrl_if ctr();

`ifdef EGGTIMER_ALARM_TIMEOUT_EN
  eggtimer_ctrl #(.ALARM_SECS(ALARM_SECS)) dut (
`else
  eggtimer_ctrl dut (
`endif
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .btn_start(btn_start), .btn_stop(btn_stop), .btn_sel(btn_sel), .btn_inc(btn_inc),
    .ctr(ctr), .sel_digit(sel_digit), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  function automatic int to_secs(input int tm, input int m, input int ts, input int s);
    return tm * 600 + m * 60 + ts * 10 + s;
  endfunction

  function automatic int digit_max(input int idx);
    return (idx == 1) ? 5 : 9;
  endfunction

  // Countdown block stand-in: loads on ctr_reset, decrements on enabled ticks, wraps like real BCD.
  int env_cnt = 0;
  always @(posedge clk) begin
    if (ctr.ctr_reset === 1'b1)
      env_cnt <= to_secs(int'(ctr.tens_minutes_prog), int'(ctr.minutes_prog),
                         int'(ctr.tens_seconds_prog), int'(ctr.seconds_prog));
    else if (ctr.main_enable === 1'b1 && tick_1hz)
      env_cnt <= (env_cnt == 0) ? 5999 : env_cnt - 1;
  end
  assign ctr.seconds      = 4'(env_cnt % 10);
  assign ctr.tens_seconds = 4'((env_cnt / 10) % 6);
  assign ctr.minutes      = 4'((env_cnt / 60) % 10);
  assign ctr.tens_minutes = 4'(env_cnt / 600);

  // Reference model: 0 idle, 1 run, 2 pause, 3 done; count kept as plain seconds.
  int m_state = 0;
  int m_prog[4] = '{0, 0, 0, 0};
  int m_sel = 0;
  int m_cnt = 0;
  int m_acnt = 0;

  typedef struct packed {
    logic [2:0]  st;
    logic        al;
    logic        me;
    logic        cr;
    logic [15:0] prog;
    logic [1:0]  sel;
    logic [12:0] cnt;
  } snap_t;

  snap_t sbq[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic model_step(input bit r, tk, st, sp, sl, ic);
    int  old_state = m_state;
    bit  pz = (m_prog[0] == 0) && (m_prog[1] == 0) && (m_prog[2] == 0) && (m_prog[3] == 0);
    bit  cz = (m_cnt == 0);
    if (old_state == 0)
      m_cnt = to_secs(m_prog[3], m_prog[2], m_prog[1], m_prog[0]);
    else if (old_state == 1 && !cz && tk)
      m_cnt = m_cnt - 1;
    if (r) begin
      m_state = 0;
      m_prog = '{0, 0, 0, 0};
      m_sel = 0;
      m_acnt = 0;
      return;
    end
    case (old_state)
      0: begin
        if (ic) m_prog[m_sel] = (m_prog[m_sel] + 1) % (digit_max(m_sel) + 1);
        if (sl) m_sel = (m_sel + 1) % 4;
        if (!sp && st && !pz) m_state = 1;
      end
      1: begin
        if (sp) m_state = 0;
        else if (cz) begin m_state = 3; m_acnt = 0; end
        else if (st) m_state = 2;
      end
      2: begin
        if (sp) m_state = 0;
        else if (st) m_state = 1;
      end
      default: begin
        if (st || sp || sl || ic) m_state = 0;
`ifdef EGGTIMER_ALARM_TIMEOUT_EN
        else if (tk) begin
          if (m_acnt == ALARM_SECS - 1) m_state = 0;
          else m_acnt = m_acnt + 1;
        end
`endif
      end
    endcase
  endtask

  // One clock: record what the DUT must show after this edge, then drive the next inputs.
  task automatic cyc(input bit r, tk, st, sp, sl, ic);
    snap_t e;
    @(posedge clk);
    #2;
    e.st   = 3'(m_state);
    e.al   = (m_state == 3);
    e.me   = (m_state == 1) && (m_cnt != 0);
    e.cr   = (m_state == 0);
    e.prog = {4'(m_prog[3]), 4'(m_prog[2]), 4'(m_prog[1]), 4'(m_prog[0])};
    e.sel  = 2'(m_sel);
    e.cnt  = 13'(m_cnt);
    sbq.push_back(e);
    reset = r; tick_1hz = tk; btn_start = st; btn_stop = sp; btn_sel = sl; btn_inc = ic;
    model_step(r, tk, st, sp, sl, ic);
  endtask

  task automatic press(input bit st, sp, sl, ic);
    cyc(1'b0, 1'b0, st, sp, sl, ic);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      snap_t e;
      e = sbq.pop_front();
      chk("state",       16'(state),                 16'(e.st));
      chk("alarm",       16'(alarm),                 16'(e.al));
      chk("main_enable", 16'(ctr.main_enable),       16'(e.me));
      chk("ctr_reset",   16'(ctr.ctr_reset),         16'(e.cr));
      chk("prog",        {ctr.tens_minutes_prog, ctr.minutes_prog,
                          ctr.tens_seconds_prog, ctr.seconds_prog}, e.prog);
      chk("sel_digit",   16'(sel_digit),             16'(e.sel));
      chk("count",       16'(env_cnt),               16'(e.cnt));
    end
  end

  initial begin
    do_reset();
    // 0:0:2:3 entry
    for (int i = 0; i < 3; i++) press(0, 0, 0, 1);
    press(0, 0, 1, 0);
    for (int i = 0; i < 2; i++) press(0, 0, 0, 1);
    idle(2);
    // digit wrap limits
    do_reset();
    for (int i = 0; i < 10; i++) press(0, 0, 0, 1);
    press(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) press(0, 0, 0, 1);
    press(0, 0, 1, 1);
    press(0, 0, 1, 1);
    press(0, 0, 1, 1);
    idle(1);
    // start ignored at zero; start+inc in one cycle uses pre-edit zero
    do_reset();
    press(1, 0, 0, 0);
    press(1, 0, 0, 1);
    idle(2);
    for (int i = 0; i < 4; i++) press(0, 0, 0, 1);
    press(1, 0, 0, 0);
    ticks(5);
    idle(3);
    press(0, 0, 0, 1);
    idle(2);
    // pause / resume / stop+start
    press(1, 0, 0, 0);
    ticks(1);
    press(1, 0, 0, 0);
    ticks(3);
    press(1, 0, 0, 0);
    ticks(1);
    press(1, 1, 0, 0);
    idle(2);
    // reset mid run
    press(1, 0, 0, 0);
    ticks(2);
    cyc(1, 1, 0, 0, 0, 0);
    idle(2);
    // long alarm hold / timeout
    for (int i = 0; i < 3; i++) press(0, 0, 0, 1);
    press(1, 0, 0, 0);
    ticks(3);
    idle(2);
    ticks(300);
    press(0, 1, 0, 0);
    idle(2);
    // randomized traffic
    for (int i = 0; i < 20000; i++) begin
      cyc($urandom_range(2999) == 0, $urandom_range(3) != 0,
          $urandom_range(39) == 0, $urandom_range(1499) == 0,
          $urandom_range(29) == 0, $urandom_range(7) == 0);
    end
    idle(2);
    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
